// File: rtl/lcd_bus_responder_if.sv
// rtl/lcd_bus_responder_if.sv - HD44780-style LCD write bus (db/rs/e/p) with driver and responder views.
interface lcd_bus_responder_if;
  logic [7:0] lcd_db;
  logic       lcd_rs;
  logic       lcd_e;
  logic       lcd_p;

  modport master (output lcd_db, output lcd_rs, output lcd_e, output lcd_p);
  modport slave  (input  lcd_db, input  lcd_rs, input  lcd_e, input  lcd_p);
endinterface

// File: rtl/lcd_bus_responder.sv
// rtl/lcd_bus_responder.sv - LCD bus responder: command decode, 2x16 display RAM, busy emulation.
// Optional LCD_RX_SHADOW_EN adds lcd_text, a flattened live copy of the display RAM.
module lcd_bus_responder #(
  parameter int BUSY_CYC = 2000,
  parameter int CLR_CYC  = 82000
) (
  input  logic                 ckht,
  input  logic                 rst,
  lcd_bus_responder_if.slave   bus,
  input  logic [4:0]           rd_addr,
  output logic [7:0]           rd_data,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_code,
  output logic                 data_valid,
  output logic [4:0]           cursor_addr,
  output logic                 display_on,
  output logic                 busy,
`ifdef LCD_RX_SHADOW_EN
  output logic [255:0]         lcd_text,
`endif
  output logic                 err_busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  clr_idx_q, clr_idx_d;
  logic [4:0]  cursor_q, cursor_d;
  logic        inc_q, inc_d;
  logic        disp_q, disp_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        data_valid_q, data_valid_d;
  logic        err_q, err_d;
  logic [7:0]  rd_data_q;
  logic [7:0]  ram_q [32];

  logic        ram_we;
  logic [4:0]  ram_waddr;
  logic [7:0]  ram_wdata;

  logic        e_s1, e_s2, e_s3;
  logic        p_s1, p_s2;
  logic        rs_s1, rs_s2, rs_s3;
  logic [7:0]  db_s1, db_s2, db_s3;
  logic        strobe;

  // s3 lags s2 by one clock, so rs/db at s3 are the values from the last clock lcd_e was high
  always_ff @(posedge ckht) begin
    if (rst) begin
      e_s1  <= 1'b0; e_s2  <= 1'b0; e_s3  <= 1'b0;
      p_s1  <= 1'b0; p_s2  <= 1'b0;
      rs_s1 <= 1'b0; rs_s2 <= 1'b0; rs_s3 <= 1'b0;
      db_s1 <= 8'h00; db_s2 <= 8'h00; db_s3 <= 8'h00;
    end else begin
      e_s1  <= bus.lcd_e;  e_s2  <= e_s1;  e_s3  <= e_s2;
      p_s1  <= bus.lcd_p;  p_s2  <= p_s1;
      rs_s1 <= bus.lcd_rs; rs_s2 <= rs_s1; rs_s3 <= rs_s2;
      db_s1 <= bus.lcd_db; db_s2 <= db_s1; db_s3 <= db_s2;
    end
  end

  assign strobe = e_s3 & ~e_s2 & p_s2;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clr_idx_d    = clr_idx_q;
    cursor_d     = cursor_q;
    inc_d        = inc_q;
    disp_d       = disp_q;
    cmd_code_d   = cmd_code_q;
    cmd_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    err_d        = err_q;
    ram_we       = 1'b0;
    ram_waddr    = cursor_q;
    ram_wdata    = db_s3;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          state_d = WAIT;
          cnt_d   = 32'(BUSY_CYC - 1);
          if (rs_s3) begin
            ram_we       = 1'b1;
            data_valid_d = 1'b1;
            cursor_d     = inc_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = db_s3;
            // casez order encodes "highest set bit wins"
            casez (db_s3)
              8'b1???????: cursor_d = {db_s3[6], db_s3[3:0]};
              8'b01??????: ;
              8'b001?????: ;
              8'b0001????: begin
                if (!db_s3[3]) cursor_d = db_s3[2] ? cursor_q + 5'd1 : cursor_q - 5'd1;
              end
              8'b00001???: disp_d   = db_s3[2];
              8'b000001??: inc_d    = db_s3[1];
              8'b0000001?: cursor_d = 5'd0;
              8'b00000001: begin
                state_d   = CLEAR;
                clr_idx_d = 5'd0;
                cursor_d  = 5'd0;
                inc_d     = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_idx_q;
        ram_wdata = 8'h20;
        clr_idx_d = clr_idx_q + 5'd1;
        if (strobe) err_d = 1'b1;
        if (clr_idx_q == 5'd31) begin
          state_d = (CLR_CYC > 32) ? WAIT : IDLE;
          cnt_d   = (CLR_CYC > 32) ? 32'(CLR_CYC - 33) : 32'd0;
        end
      end
      WAIT: begin
        if (strobe) err_d = 1'b1;
        if (cnt_q == 32'd0) state_d = IDLE;
        else                cnt_d   = cnt_q - 32'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ckht) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 32'd0;
      clr_idx_q    <= 5'd0;
      cursor_q     <= 5'd0;
      inc_q        <= 1'b1;
      disp_q       <= 1'b0;
      cmd_code_q   <= 8'h00;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rd_data_q    <= 8'h00;
      for (int i = 0; i < 32; i++) ram_q[i] <= 8'h20;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clr_idx_q    <= clr_idx_d;
      cursor_q     <= cursor_d;
      inc_q        <= inc_d;
      disp_q       <= disp_d;
      cmd_code_q   <= cmd_code_d;
      cmd_valid_q  <= cmd_valid_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
      rd_data_q    <= ram_q[rd_addr];
      if (ram_we) ram_q[ram_waddr] <= ram_wdata;
    end
  end

  assign rd_data     = rd_data_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign data_valid  = data_valid_q;
  assign cursor_addr = cursor_q;
  assign display_on  = disp_q;
  assign busy        = (state_q != IDLE);
  assign err_busy    = err_q;

`ifdef LCD_RX_SHADOW_EN
  always_comb begin
    lcd_text = '0;
    for (int i = 0; i < 32; i++) lcd_text[8*i +: 8] = ram_q[i];
  end
`endif

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb/tb_lcd_bus_responder.sv - directed self-checking bench for lcd_bus_responder.
module tb_lcd_bus_responder;
  localparam int BUSY_CYC = 20;
  localparam int CLR_CYC  = 80;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       cmd_valid, data_valid, display_on, busy, err_busy;
  logic [7:0] cmd_code;
  logic [4:0] cursor_addr;
`ifdef LCD_RX_SHADOW_EN
  logic [255:0] lcd_text;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_cmdv = 0;
  int n_datv = 0;

  lcd_bus_responder_if bus ();

  lcd_bus_responder #(.BUSY_CYC(BUSY_CYC), .CLR_CYC(CLR_CYC)) dut (
    .ckht(clk), .rst(rst), .bus(bus), .rd_addr(rd_addr), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .data_valid(data_valid),
    .cursor_addr(cursor_addr), .display_on(display_on), .busy(busy),
`ifdef LCD_RX_SHADOW_EN
    .lcd_text(lcd_text),
`endif
    .err_busy(err_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid === 1'b1)  n_cmdv++;
    if (data_valid === 1'b1) n_datv++;
  end

  task automatic write_bus(input logic rs, input logic [7:0] db, input int post);
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_db = db; bus.lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    bus.lcd_e = 1'b0;
    repeat (post) @(negedge clk);
  endtask

  task automatic read_ram(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk); rd_addr = a;
    @(negedge clk); d = rd_data;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    n_cmp++; if (cmd_code !== 8'h00) begin n_err++; $display("FAIL reset_cmd_code got %h want 00", cmd_code); end
    rst = 1'b0;
    n_cmp++; if (cursor_addr !== 5'd0) begin n_err++; $display("FAIL reset_cursor got %0d want 0", cursor_addr); end
    n_cmp++; if ({busy, display_on, err_busy, cmd_valid, data_valid} !== 5'b0)
      begin n_err++; $display("FAIL reset_flags got %b want 00000", {busy, display_on, err_busy, cmd_valid, data_valid}); end
    for (int a = 0; a < 32; a++) begin
      read_ram(5'(a), v);
      n_cmp++; if (v !== 8'h20) begin n_err++; $display("FAIL reset_ram[%0d] got %h want 20", a, v); end
    end
  endtask

  task automatic test_data_write;
    logic [7:0] v;
    int c0, d0;
    c0 = n_cmdv; d0 = n_datv;
    write_bus(1'b0, 8'h0C, BUSY_CYC + 6);
    write_bus(1'b1, 8'h41, BUSY_CYC + 6);
    write_bus(1'b1, 8'h42, BUSY_CYC + 6);
    read_ram(5'd0, v);
    n_cmp++; if (v !== 8'h41) begin n_err++; $display("FAIL data_ram0 got %h want 41", v); end
    read_ram(5'd1, v);
    n_cmp++; if (v !== 8'h42) begin n_err++; $display("FAIL data_ram1 got %h want 42", v); end
    n_cmp++; if (cursor_addr !== 5'd2) begin n_err++; $display("FAIL data_cursor got %0d want 2", cursor_addr); end
    n_cmp++; if (display_on !== 1'b1) begin n_err++; $display("FAIL data_display_on got %b want 1", display_on); end
    n_cmp++; if (n_datv - d0 !== 2) begin n_err++; $display("FAIL data_pulses got %0d want 2", n_datv - d0); end
    n_cmp++; if (n_cmdv - c0 !== 1) begin n_err++; $display("FAIL cmd_pulses got %0d want 1", n_cmdv - c0); end
    n_cmp++; if (cmd_code !== 8'h0C) begin n_err++; $display("FAIL data_cmd_code got %h want 0C", cmd_code); end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    write_bus(1'b0, 8'hCF, BUSY_CYC + 6);
    n_cmp++; if (cursor_addr !== 5'd31) begin n_err++; $display("FAIL wrap_ddram_cf got %0d want 31", cursor_addr); end
    write_bus(1'b1, 8'h39, BUSY_CYC + 6);
    n_cmp++; if (cursor_addr !== 5'd0) begin n_err++; $display("FAIL wrap_inc got %0d want 0", cursor_addr); end
    write_bus(1'b1, 8'h30, BUSY_CYC + 6);
    n_cmp++; if (cursor_addr !== 5'd1) begin n_err++; $display("FAIL wrap_cursor1 got %0d want 1", cursor_addr); end
    read_ram(5'd31, v);
    n_cmp++; if (v !== 8'h39) begin n_err++; $display("FAIL wrap_ram31 got %h want 39", v); end
    read_ram(5'd0, v);
    n_cmp++; if (v !== 8'h30) begin n_err++; $display("FAIL wrap_ram0 got %h want 30", v); end
    write_bus(1'b0, 8'hBF, BUSY_CYC + 6);
    n_cmp++; if (cursor_addr !== 5'd15) begin n_err++; $display("FAIL ddram_bf got %0d want 15", cursor_addr); end
    write_bus(1'b1, 8'h2A, BUSY_CYC + 6);
    n_cmp++; if (cursor_addr !== 5'd16) begin n_err++; $display("FAIL line_cross got %0d want 16", cursor_addr); end
    write_bus(1'b0, 8'h02, BUSY_CYC + 6);
    n_cmp++; if (cursor_addr !== 5'd0) begin n_err++; $display("FAIL home got %0d want 0", cursor_addr); end
    write_bus(1'b0, 8'h04, BUSY_CYC + 6);
    write_bus(1'b1, 8'h31, BUSY_CYC + 6);
    n_cmp++; if (cursor_addr !== 5'd31) begin n_err++; $display("FAIL wrap_dec got %0d want 31", cursor_addr); end
    read_ram(5'd0, v);
    n_cmp++; if (v !== 8'h31) begin n_err++; $display("FAIL dec_ram0 got %h want 31", v); end
    write_bus(1'b0, 8'h14, BUSY_CYC + 6);
    n_cmp++; if (cursor_addr !== 5'd0) begin n_err++; $display("FAIL shift_right got %0d want 0", cursor_addr); end
    write_bus(1'b0, 8'h10, BUSY_CYC + 6);
    n_cmp++; if (cursor_addr !== 5'd31) begin n_err++; $display("FAIL shift_left got %0d want 31", cursor_addr); end
    write_bus(1'b0, 8'h1C, BUSY_CYC + 6);
    n_cmp++; if (cursor_addr !== 5'd31) begin n_err++; $display("FAIL display_shift got %0d want 31", cursor_addr); end
    write_bus(1'b0, 8'h00, BUSY_CYC + 6);
    n_cmp++; if (cmd_code !== 8'h00) begin n_err++; $display("FAIL cmd_zero got %h want 00", cmd_code); end
  endtask

  task automatic test_clear;
    logic [7:0] v;
    int bcnt;
    bcnt = 0;
    @(negedge clk);
    bus.lcd_rs = 1'b0; bus.lcd_db = 8'h01; bus.lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    bus.lcd_e = 1'b0;
    for (int i = 0; i < CLR_CYC + 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
    end
    n_cmp++; if (bcnt !== CLR_CYC) begin n_err++; $display("FAIL clear_busy_len got %0d want %0d", bcnt, CLR_CYC); end
    n_cmp++; if (cursor_addr !== 5'd0) begin n_err++; $display("FAIL clear_cursor got %0d want 0", cursor_addr); end
    n_cmp++; if (cmd_code !== 8'h01) begin n_err++; $display("FAIL clear_cmd_code got %h want 01", cmd_code); end
    for (int a = 0; a < 32; a++) begin
      read_ram(5'(a), v);
      n_cmp++; if (v !== 8'h20) begin n_err++; $display("FAIL clear_ram[%0d] got %h want 20", a, v); end
    end
    write_bus(1'b1, 8'h41, BUSY_CYC + 6);
    n_cmp++; if (cursor_addr !== 5'd1) begin n_err++; $display("FAIL clear_inc_mode got %0d want 1", cursor_addr); end
  endtask

  task automatic test_busy_err;
    logic [7:0] v;
    int d0;
    d0 = n_datv;
    n_cmp++; if (err_busy !== 1'b0) begin n_err++; $display("FAIL err_before got %b want 0", err_busy); end
    write_bus(1'b0, 8'h01, 10);
    write_bus(1'b1, 8'h55, CLR_CYC + 10);
    n_cmp++; if (err_busy !== 1'b1) begin n_err++; $display("FAIL err_busy got %b want 1", err_busy); end
    n_cmp++; if (n_datv - d0 !== 0) begin n_err++; $display("FAIL busy_data_pulse got %0d want 0", n_datv - d0); end
    n_cmp++; if (cursor_addr !== 5'd0) begin n_err++; $display("FAIL busy_cursor got %0d want 0", cursor_addr); end
    read_ram(5'd0, v);
    n_cmp++; if (v !== 8'h20) begin n_err++; $display("FAIL busy_ram0 got %h want 20", v); end
  endtask

  task automatic test_power_off;
    logic [7:0] v;
    int c0, d0;
    c0 = n_cmdv; d0 = n_datv;
    @(negedge clk); bus.lcd_p = 1'b0;
    repeat (3) @(negedge clk);
    write_bus(1'b1, 8'h77, 8);
    write_bus(1'b0, 8'h08, 8);
    bus.lcd_p = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if ((n_cmdv - c0) + (n_datv - d0) !== 0) begin n_err++; $display("FAIL power_pulses got %0d want 0", (n_cmdv - c0) + (n_datv - d0)); end
    n_cmp++; if (display_on !== 1'b1) begin n_err++; $display("FAIL power_display got %b want 1", display_on); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL power_busy got %b want 0", busy); end
    read_ram(5'd0, v);
    n_cmp++; if (v !== 8'h20) begin n_err++; $display("FAIL power_ram0 got %h want 20", v); end
  endtask

  task automatic test_reset_mid_clear;
    logic [7:0] v;
    write_bus(1'b0, 8'h8F, BUSY_CYC + 6);
    write_bus(1'b1, 8'h41, BUSY_CYC + 6);
    write_bus(1'b0, 8'h01, 10);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midclr_busy_pre got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midclr_busy got %b want 0", busy); end
    n_cmp++; if ({display_on, err_busy, cmd_code} !== 10'b0) begin n_err++; $display("FAIL midclr_state got %b want 0", {display_on, err_busy, cmd_code}); end
    n_cmp++; if (cursor_addr !== 5'd0) begin n_err++; $display("FAIL midclr_cursor got %0d want 0", cursor_addr); end
    read_ram(5'd15, v);
    n_cmp++; if (v !== 8'h20) begin n_err++; $display("FAIL midclr_ram15 got %h want 20", v); end
  endtask

`ifdef LCD_RX_SHADOW_EN
  task automatic test_shadow;
    logic [159:0] exp_text;
    logic [7:0]   ch;
    exp_text = '0;
    write_bus(1'b0, 8'h80, BUSY_CYC + 6);
    for (int i = 0; i < 20; i++) begin
      ch = 8'h41 + 8'(i);
      exp_text[8*i +: 8] = ch;
      write_bus(1'b1, ch, BUSY_CYC + 6);
    end
    n_cmp++; if (lcd_text[159:0] !== exp_text) begin n_err++; $display("FAIL shadow_text got %h want %h", lcd_text[159:0], exp_text); end
    n_cmp++; if (lcd_text[255:160] !== {12{8'h20}}) begin n_err++; $display("FAIL shadow_tail got %h", lcd_text[255:160]); end
  endtask
`endif

  initial begin
    rst = 1'b0; rd_addr = 5'd0;
    bus.lcd_db = 8'h00; bus.lcd_rs = 1'b0; bus.lcd_e = 1'b0; bus.lcd_p = 1'b1;
    test_reset();
    test_data_write();
    test_wrap();
    test_clear();
    test_busy_err();
    test_power_off();
    test_reset_mid_clear();
`ifdef LCD_RX_SHADOW_EN
    test_shadow();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
